// File: rtl/tb_cmd_pkg.sv
// Shared types for the scenario command sequencer: opcodes and FSM states.
package tb_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_SET = 2'd0,
        CMD_WTR = 2'd1,
        CMD_WTF = 2'd2,
        CMD_CHK = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/tb_cmd_timer.sv
// Per-command timeout counter: load captures the limit and clears the count.
module tb_cmd_timer #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [TMO_W-1:0] i_tmo,
    output logic             o_expire
);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tmo_d = tmo_q;
        cnt_d = cnt_q;
        if (i_load) begin
            tmo_d = i_tmo;
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            cnt_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the timeout entirely.
    assign o_expire = i_en && (tmo_q != '0) && (cnt_q == tmo_q - 1'b1);

endmodule

// File: rtl/tb_cmd_sequencer.sv
// Executes scenario commands one at a time by steering them to set/wait/check units.
module tb_cmd_sequencer
    import tb_cmd_pkg::*;
#(
    parameter int ARG_W = 8,
    parameter int TMO_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    input  cmd_op_t          i_cmd_op,
    input  logic [ARG_W-1:0] i_cmd_arg,
    input  logic [TMO_W-1:0] i_cmd_tmo,
    output logic             o_cmd_ready,
    output logic             o_sel_set,
    output logic             o_sel_wait,
    output logic             o_sel_check,
    output logic             o_wait_edge,
    output logic [ARG_W-1:0] o_arg,
    input  logic             i_set_done,
    input  logic             i_wait_done,
    input  logic             i_check_done,
    input  logic             i_check_ok,
    output logic             o_ack,
    output logic             o_busy,
    output logic             o_err_tmo,
    output logic             o_err_chk,
    input  logic             i_err_clr,
    output logic [CNT_W-1:0] o_cmd_cnt
);

    seq_state_t       state_q, state_d;
    cmd_op_t          op_q, op_d;
    logic [ARG_W-1:0] arg_q, arg_d;
    logic             aborted_q, aborted_d;
    logic             err_tmo_q, err_tmo_d;
    logic             err_chk_q, err_chk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic tmr_load, tmr_en, tmr_expire;
    logic unit_done, set_tmo, set_chk;

    tb_cmd_timer #(.TMO_W(TMO_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (tmr_load),
        .i_en     (tmr_en),
        .i_tmo    (i_cmd_tmo),
        .o_expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_d       = arg_q;
        aborted_d   = aborted_q;
        cnt_d       = cnt_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        set_tmo     = 1'b0;
        set_chk     = 1'b0;
        unit_done   = 1'b0;
        o_cmd_ready = 1'b0;
        o_sel_set   = 1'b0;
        o_sel_wait  = 1'b0;
        o_sel_check = 1'b0;
        o_wait_edge = 1'b0;
        o_ack       = 1'b0;
        o_busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    op_d      = i_cmd_op;
                    arg_d     = i_cmd_arg;
                    aborted_d = 1'b0;
                    tmr_load  = 1'b1;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_busy = 1'b1;
                tmr_en = 1'b1;
                case (op_q)
                    CMD_SET: begin
                        o_sel_set = 1'b1;
                        unit_done = i_set_done;
                    end
                    CMD_WTR, CMD_WTF: begin
                        o_sel_wait  = 1'b1;
                        o_wait_edge = (op_q == CMD_WTR);
                        unit_done   = i_wait_done;
                    end
                    default: begin
                        o_sel_check = 1'b1;
                        unit_done   = i_check_done;
                    end
                endcase
                // Completion takes priority over a timeout landing in the same cycle.
                if (unit_done) begin
                    set_chk = (op_q == CMD_CHK) && !i_check_ok;
                    state_d = ST_DONE;
                end else if (tmr_expire) begin
                    set_tmo   = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                o_ack = 1'b1;
                if (!aborted_q) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        err_tmo_d = set_tmo | (err_tmo_q & ~i_err_clr);
        err_chk_d = set_chk | (err_chk_q & ~i_err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= CMD_SET;
            arg_q     <= '0;
            aborted_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_chk_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            aborted_q <= aborted_d;
            err_tmo_q <= err_tmo_d;
            err_chk_q <= err_chk_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_arg     = arg_q;
    assign o_err_tmo = err_tmo_q;
    assign o_err_chk = err_chk_q;
    assign o_cmd_cnt = cnt_q;

endmodule

// File: doc/tb_cmd_sequencer.md
TB_CMD_SEQUENCER -- requirements
Module: tb_cmd_sequencer

Interface
REQ-001 Parameters (name, default, meaning): ARG_W, 8, command argument width (signal/collection index); TMO_W, 16, timeout counter width; CNT_W, 16, executed-command counter width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- i_cmd_valid, in, 1, parsed scenario command present.
- i_cmd_op, in, cmd_op_t (2), opcode: SET, WTR, WTF, CHK.
- i_cmd_arg, in, ARG_W, target index.
- i_cmd_tmo, in, TMO_W, timeout in cycles; 0 = no timeout.
- o_cmd_ready, out, 1, sequencer accepts a command.
- o_sel_set / o_sel_wait / o_sel_check, out, 1 each, one-hot unit select, held during execution.
- o_wait_edge, out, 1, 1 = rising (WTR), 0 = falling (WTF).
- o_arg, out, ARG_W, latched argument to selected unit.
- i_set_done / i_wait_done / i_check_done, in, 1 each, unit completion pulses.
- i_check_ok, in, 1, check result, qualified by i_check_done.
- o_ack, out, 1, one-cycle pulse per completed or aborted command.
- o_busy, out, 1, command in execution.
- o_err_tmo / o_err_chk, out, 1 each, sticky error flags.
- i_err_clr, in, 1, clears sticky flags.
- o_cmd_cnt, out, CNT_W, commands completed.

Function
REQ-003 FSM states IDLE, EXEC, DONE; only IDLE asserts o_cmd_ready.
REQ-004 IDLE: i_cmd_valid & o_cmd_ready latches op, arg, tmo; next cycle EXEC; timeout counter cleared.
REQ-005 EXEC: exactly one select asserted per latched op (SET->o_sel_set; WTR/WTF->o_sel_wait; CHK->o_sel_check); o_wait_edge=1 for WTR, 0 otherwise; o_busy=1.
REQ-006 EXEC: timeout counter increments each cycle; done of the selected unit only -> DONE; done of non-selected units ignored.
REQ-007 Timeout: tmo!=0 and counter == tmo-1 with no done -> o_err_tmo=1, go DONE (command aborted).
REQ-008 Done and timeout in same cycle: done wins, no timeout error.
REQ-009 CHK: i_check_done with i_check_ok=0 sets o_err_chk.
REQ-010 DONE: selects deasserted, o_ack=1 for one cycle, o_cmd_cnt +1 (only if not aborted), next IDLE; command-to-ack latency = done cycle + 1.
REQ-011 o_cmd_cnt wraps modulo 2^CNT_W.
REQ-012 i_err_clr clears both flags next cycle; a setting event in same cycle wins (flag stays 1).
REQ-013 tmo=0: EXEC waits indefinitely for done.

Reset
REQ-014 rst synchronous: state IDLE, all selects/o_ack/o_busy/flags 0, o_arg 0, o_cmd_cnt 0, counters 0.
REQ-015 rst mid-EXEC aborts command without o_ack; o_cmd_ready=1 first cycle after reset release.

Structure
REQ-016 Package tb_cmd_pkg holds cmd_op_t enum (SET=0, WTR=1, WTF=2, CHK=3) and state typedef.
REQ-017 One sub-module tb_cmd_timer (load, enable, expire flag) holds the timeout counter.

Verification
REQ-018 SET arg=5 tmo=10, i_set_done 3 cycles later -> o_sel_set 3 cycles, o_arg=5, o_ack pulse, o_cmd_cnt=1, no errors.
REQ-019 WTR tmo=4, no done -> o_err_tmo=1 after 4 EXEC cycles, o_ack pulse, o_cmd_cnt unchanged.
REQ-020 CHK, i_check_done with i_check_ok=0 -> o_err_chk=1; i_err_clr -> 0 next cycle.
REQ-021 WTF tmo=4, i_wait_done on 4th EXEC cycle -> no timeout, o_wait_edge=0, o_cmd_cnt+1.
REQ-022 rst during EXEC of CHK -> no o_ack, all outputs at reset values, next command accepted normally.
REQ-023 Back-to-back valid commands with spurious i_check_done during SET -> ignored; commands executed in order, one ack each.
